// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg -- data shared by the DES S-box round stage.
//
// Contents:
//   des_state_e  : FSM state encoding (IDLE / SUB / DONE) of des_sbox_stage
//   SBOX_TABLE   : the eight DES S-boxes, 64 entries of 4 bits each,
//                  addressed as row*16 + col (row = {b0,b5}, col = b1..b4)
//   P_TABLE      : DES straight P-permutation, zero-based source bit per
//                  output bit (bit 0 = MSB, DES bit order)
//   p_permute()  : applies P_TABLE to a 32-bit S-box result
// -----------------------------------------------------------------------------
package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } des_state_e;

  localparam logic [3:0] SBOX_TABLE [0:7][0:63] = '{
    // S1
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    // S2
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    // S3
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    // S4
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    // S5
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    // S6
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    // S7
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    // S8
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  // Output bit i of P takes result bit P_TABLE[i] (both zero-based, MSB = 0).
  localparam logic [4:0] P_TABLE [0:31] = '{
    15,  6, 19, 20, 28, 11, 27, 16,
     0, 14, 22, 25,  4, 17, 30,  9,
     1,  7, 23, 13, 31, 26,  2,  8,
    18, 12, 29,  5, 21, 10,  3, 24
  };

  function automatic logic [0:31] p_permute(input logic [0:31] r);
    logic [0:31] p;
    for (int i = 0; i < 32; i++) begin
      p[i] = r[P_TABLE[i]];
    end
    return p;
  endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// -----------------------------------------------------------------------------
// des_sbox_lut -- one combinational DES S-box lookup.
//
// Ports:
//   sbox_idx [2:0] : which S-box (0 = S1 .. 7 = S8)
//   six      [0:5] : 6-bit input group, DES bit order (b0 = MSB)
//   val      [0:3] : 4-bit S-box output
// -----------------------------------------------------------------------------
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0] sbox_idx,
  input  logic [0:5] six,
  output logic [0:3] val
);

  // Outer bits select the row, inner four bits the column.
  logic [5:0] addr;

  always_comb begin
    addr = {six[0], six[5], six[1:4]};
  end

  assign val = SBOX_TABLE[sbox_idx][addr];

endmodule

// File: rtl/des_sbox_stage.sv
// -----------------------------------------------------------------------------
// des_sbox_stage -- DES round substitution stage: x = e_in ^ subkey, then the
// eight S-boxes, SBOX_PER_CYCLE of them per clock, optionally followed by the
// straight P-permutation.
//
// Configuration macro: DES_SBOX_PBOX_EN
//   defined   : s_out = P(result)
//   undefined : s_out = result (raw S1..S8 concatenation)
//   Latency and handshake are identical in both builds.
//
// Parameter:
//   SBOX_PER_CYCLE : S-boxes evaluated per clock (1, 2, 4 or 8);
//                    one operation takes 8/SBOX_PER_CYCLE SUB cycles.
//
// Ports (all buses in DES bit order, index 0 = MSB):
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid        : e_in/subkey valid
//   in_ready        : high only in IDLE
//   e_in   [0:47]   : expanded right half
//   subkey [0:47]   : round key
//   out_valid       : s_out valid, high only in DONE
//   out_ready       : consumer takes s_out
//   s_out  [0:31]   : substituted (optionally permuted) result
//   busy            : high whenever the FSM is not IDLE
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer keeps its data stable while valid is high and
// ready is low; valid never depends combinationally on ready. Here in_ready
// and out_valid are registered, so an operand is taken only in IDLE and the
// result is held in DONE until out_ready. No second operand overlaps.
// -----------------------------------------------------------------------------
module des_sbox_stage
  import des_pkg::*;
#(
  parameter int SBOX_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:47] e_in,
  input  logic [0:47] subkey,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] s_out,
  output logic        busy
);

  localparam int N = SBOX_PER_CYCLE;

  // Group counter steps through 0..7; with N = 8 the step wraps to 0, which
  // is harmless because the first SUB cycle is also the last.
  localparam logic [2:0] G_STEP = 3'(N);
  localparam logic [2:0] G_LAST = 3'(8 - N);

  // FSM state; the observable state of the block for checkers.
  des_state_e  state;

  logic [0:47] x;       // captured e_in ^ subkey
  logic [0:31] result;  // S1..S8 outputs, filled group by group
  logic [2:0]  g;       // first group handled in the current SUB cycle

  logic [2:0]  lane_idx [N];
  logic [0:5]  lane_six [N];
  logic [0:3]  lane_val [N];

  // Lane k handles group g+k this cycle.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      lane_idx[k] = g + 3'(k);
      lane_six[k] = x[6*int'(lane_idx[k]) +: 6];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    des_sbox_lut u_lut (
      .sbox_idx (lane_idx[k]),
      .six      (lane_six[k]),
      .val      (lane_val[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      result    <= '0;
      g         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x        <= e_in ^ subkey;
            g        <= '0;
            state    <= SUB;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        SUB: begin
          for (int k = 0; k < N; k++) begin
            result[4*int'(lane_idx[k]) +: 4] <= lane_val[k];
          end
          g <= g + G_STEP;
          if (g == G_LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end

        DONE: begin
          if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef DES_SBOX_PBOX_EN
  assign s_out = p_permute(result);
`else
  assign s_out = result;
`endif

endmodule

// File: tb/tb_des_sbox_stage.sv
// -----------------------------------------------------------------------------
// tb_des_sbox_stage -- bench for des_sbox_stage. Four instances run side by
// side (SBOX_PER_CYCLE = 1, 2, 4, 8) on shared inputs. Expected results come
// from a DES S-box / P model written from the standard tables in hex.
// -----------------------------------------------------------------------------
module tb_des_sbox_stage;

  localparam int NI = 4;
  localparam int LAT [NI] = '{8, 4, 2, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [0:47] e_in = '0;
  logic [0:47] subkey = '0;

  logic        in_ready_a  [NI];
  logic        out_valid_a [NI];
  logic        busy_a      [NI];
  logic [0:31] s_out_a     [NI];

  for (genvar j = 0; j < NI; j++) begin : g_dut
    des_sbox_stage #(.SBOX_PER_CYCLE(1 << j)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a[j]),
      .e_in      (e_in),
      .subkey    (subkey),
      .out_valid (out_valid_a[j]),
      .out_ready (out_ready),
      .s_out     (s_out_a[j]),
      .busy      (busy_a[j])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Each S-box as 64 hex nibbles, entry 0 first (row-major, 16 per row).
  localparam logic [255:0] TB_SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };
  localparam int TB_P [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                               2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  function automatic logic [31:0] model_sub(input logic [47:0] xv);
    logic [255:0] t;
    logic [5:0]   s;
    logic [31:0]  r;
    int           n;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      s = xv[47-6*i -: 6];
      n = int'({s[5], s[0]}) * 16 + int'(s[4:1]);
      t = TB_SBOX[i];
      r[31-4*i -: 4] = t[255-4*n -: 4];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_p(input logic [31:0] r);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[31-i] = r[32-TB_P[i]];
    return o;
  endfunction

  function automatic logic [31:0] model(input logic [47:0] e, input logic [47:0] k);
`ifdef DES_SBOX_PBOX_EN
    return model_p(model_sub(e ^ k));
`else
    return model_sub(e ^ k);
`endif
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  // ---------------- driver / monitor ----------------
  bit          obs_seen [NI];
  int          obs_lat  [NI];
  logic [31:0] obs_val  [NI];

  // One operand into all instances (all idle), out_ready left as the caller
  // set it; records first out_valid per instance and its edge distance.
  task automatic run_single(input logic [47:0] e, input logic [47:0] k, input bit junk);
    int acc;
    @(negedge clk);
    e_in = e; subkey = k; in_valid = 1'b1;
    acc = edges + 1;
    for (int j = 0; j < NI; j++) begin
      obs_seen[j] = 1'b0; obs_lat[j] = -1; obs_val[j] = '0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      for (int j = 0; j < NI; j++) begin
        if (out_valid_a[j] && !obs_seen[j]) begin
          obs_seen[j] = 1'b1;
          obs_lat[j]  = edges - acc;
          obs_val[j]  = s_out_a[j];
        end
      end
      if (junk) begin
        e_in = rand48(); subkey = rand48();
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    for (int j = 0; j < NI; j++) begin
      n_vec++; if (in_ready_a[j] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready inst=%0d got=%b exp=1", j, in_ready_a[j]); end
      n_vec++; if (out_valid_a[j] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid inst=%0d got=%b exp=0", j, out_valid_a[j]); end
      n_vec++; if (busy_a[j] !== 1'b0) begin n_err++; $display("FAIL reset_busy inst=%0d got=%b exp=0", j, busy_a[j]); end
      n_vec++; if (s_out_a[j] !== 32'h0) begin n_err++; $display("FAIL reset_s_out inst=%0d got=%h exp=00000000", j, s_out_a[j]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vectors();
    logic [47:0] ev [2];
    logic [47:0] kv [2];
    logic [31:0] cv [2];
    ev[0] = 48'h7A15557A1555; kv[0] = 48'h1B02EFFC7072;
    ev[1] = 48'h0;            kv[1] = 48'h0;
`ifdef DES_SBOX_PBOX_EN
    cv[0] = 32'h234AA9BB;
    cv[1] = model_p(32'hEFA72C4D);
`else
    cv[0] = 32'h5C82B597;
    cv[1] = 32'hEFA72C4D;
`endif
    out_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      run_single(ev[v], kv[v], 1'b0);
      for (int j = 0; j < NI; j++) begin
        n_vec++; if (!obs_seen[j]) begin n_err++; $display("FAIL known_timeout vec=%0d inst=%0d got=no_out_valid exp=out_valid", v, j); end
        n_vec++; if (obs_lat[j] != LAT[j]) begin n_err++; $display("FAIL known_latency vec=%0d inst=%0d got=%0d exp=%0d", v, j, obs_lat[j], LAT[j]); end
        n_vec++; if (obs_val[j] !== cv[v]) begin n_err++; $display("FAIL known_s_out vec=%0d inst=%0d got=%h exp=%h", v, j, obs_val[j], cv[v]); end
      end
    end
  endtask

  task automatic test_operand_change();
    logic [47:0] e, k;
    logic [31:0] exp;
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      e = rand48(); k = rand48(); exp = model(e, k);
      run_single(e, k, 1'b1);
      for (int j = 0; j < NI; j++) begin
        n_vec++; if (obs_val[j] !== exp) begin n_err++; $display("FAIL operand_change_s_out inst=%0d got=%h exp=%h", j, obs_val[j], exp); end
        n_vec++; if (obs_lat[j] != LAT[j]) begin n_err++; $display("FAIL operand_change_latency inst=%0d got=%0d exp=%0d", j, obs_lat[j], LAT[j]); end
      end
    end
  endtask

  task automatic test_hold();
    logic [47:0] e, k;
    logic [31:0] exp;
    bit all_v;
    int w;
    e = rand48(); k = rand48(); exp = model(e, k);
    out_ready = 1'b0;
    @(negedge clk);
    e_in = e; subkey = k; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    all_v = 1'b0;
    while (!all_v && w < 12) begin
      all_v = 1'b1;
      for (int j = 0; j < NI; j++) if (out_valid_a[j] !== 1'b1) all_v = 1'b0;
      if (!all_v) begin @(negedge clk); w++; end
    end
    n_vec++; if (!all_v) begin n_err++; $display("FAIL hold_timeout got=not_all_valid exp=all_valid"); end
    in_valid = 1'b1;  // must be ignored while results are pending
    for (int h = 0; h < 10; h++) begin
      for (int j = 0; j < NI; j++) begin
        n_vec++; if (out_valid_a[j] !== 1'b1) begin n_err++; $display("FAIL hold_out_valid inst=%0d cyc=%0d got=%b exp=1", j, h, out_valid_a[j]); end
        n_vec++; if (in_ready_a[j] !== 1'b0) begin n_err++; $display("FAIL hold_in_ready inst=%0d cyc=%0d got=%b exp=0", j, h, in_ready_a[j]); end
        n_vec++; if (busy_a[j] !== 1'b1) begin n_err++; $display("FAIL hold_busy inst=%0d cyc=%0d got=%b exp=1", j, h, busy_a[j]); end
        n_vec++; if (s_out_a[j] !== exp) begin n_err++; $display("FAIL hold_s_out inst=%0d cyc=%0d got=%h exp=%h", j, h, s_out_a[j], exp); end
      end
      e_in = rand48(); subkey = rand48();
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    for (int j = 0; j < NI; j++) begin
      n_vec++; if (in_ready_a[j] !== 1'b1) begin n_err++; $display("FAIL release_in_ready inst=%0d got=%b exp=1", j, in_ready_a[j]); end
      n_vec++; if (out_valid_a[j] !== 1'b0) begin n_err++; $display("FAIL release_out_valid inst=%0d got=%b exp=0", j, out_valid_a[j]); end
      n_vec++; if (busy_a[j] !== 1'b0) begin n_err++; $display("FAIL release_busy inst=%0d got=%b exp=0", j, busy_a[j]); end
    end
  endtask

  task automatic test_reset_mid();
    bit rose [NI];
    out_ready = 1'b1;
    @(negedge clk);
    e_in = rand48(); subkey = rand48(); in_valid = 1'b1;
    @(negedge clk);           // first SUB cycle
    in_valid = 1'b0;
    @(negedge clk);           // second SUB cycle for SBOX_PER_CYCLE = 1
    rst_n = 1'b0;
    #1;
    for (int j = 0; j < NI; j++) begin
      rose[j] = 1'b0;
      n_vec++; if (in_ready_a[j] !== 1'b1) begin n_err++; $display("FAIL midreset_in_ready inst=%0d got=%b exp=1", j, in_ready_a[j]); end
      n_vec++; if (out_valid_a[j] !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid inst=%0d got=%b exp=0", j, out_valid_a[j]); end
      n_vec++; if (busy_a[j] !== 1'b0) begin n_err++; $display("FAIL midreset_busy inst=%0d got=%b exp=0", j, busy_a[j]); end
      n_vec++; if (s_out_a[j] !== 32'h0) begin n_err++; $display("FAIL midreset_s_out inst=%0d got=%h exp=00000000", j, s_out_a[j]); end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int j = 0; j < NI; j++) if (out_valid_a[j] !== 1'b0) rose[j] = 1'b1;
    end
    for (int j = 0; j < NI; j++) begin
      n_vec++; if (rose[j]) begin n_err++; $display("FAIL midreset_no_output inst=%0d got=out_valid_rose exp=never", j); end
      n_vec++; if (in_ready_a[j] !== 1'b1) begin n_err++; $display("FAIL midreset_resume inst=%0d got=%b exp=1", j, in_ready_a[j]); end
    end
  endtask

  // Scoreboard: in_valid held high, out_ready high, fresh operand each cycle.
  logic [31:0] exp_q [NI][$];

  task automatic test_back_to_back();
    int acc_edge [NI];
    int last_acc [NI];
    int n_out    [NI];
    logic [47:0] e, k;
    logic [31:0] exp;
    for (int j = 0; j < NI; j++) begin
      acc_edge[j] = 0; last_acc[j] = -1; n_out[j] = 0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 72; c++) begin
      for (int j = 0; j < NI; j++) begin
        if (out_valid_a[j] === 1'b1) begin
          n_out[j]++;
          n_vec++;
          if (exp_q[j].size() == 0) begin
            n_err++; $display("FAIL b2b_unexpected inst=%0d got=%h exp=no_output", j, s_out_a[j]);
          end else begin
            exp = exp_q[j].pop_front();
            if (s_out_a[j] !== exp) begin n_err++; $display("FAIL b2b_s_out inst=%0d got=%h exp=%h", j, s_out_a[j], exp); end
            n_vec++;
            if (edges - acc_edge[j] != LAT[j]) begin n_err++; $display("FAIL b2b_latency inst=%0d got=%0d exp=%0d", j, edges - acc_edge[j], LAT[j]); end
          end
        end
      end
      in_valid = (c < 60);
      e = rand48(); k = rand48();
      e_in = e; subkey = k;
      if (in_valid) begin
        for (int j = 0; j < NI; j++) begin
          if (in_ready_a[j] === 1'b1) begin
            exp_q[j].push_back(model(e, k));
            if (last_acc[j] >= 0) begin
              n_vec++;
              if (edges + 1 - last_acc[j] != LAT[j] + 2) begin n_err++; $display("FAIL b2b_throughput inst=%0d got=%0d exp=%0d", j, edges + 1 - last_acc[j], LAT[j] + 2); end
            end
            last_acc[j] = edges + 1;
            acc_edge[j] = edges + 1;
          end
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int j = 0; j < NI; j++) begin
      n_vec++; if (exp_q[j].size() != 0) begin n_err++; $display("FAIL b2b_drain inst=%0d got=%0d_pending exp=0", j, exp_q[j].size()); end
      n_vec++; if (n_out[j] < 60 / (LAT[j] + 2)) begin n_err++; $display("FAIL b2b_count inst=%0d got=%0d exp_min=%0d", j, n_out[j], 60 / (LAT[j] + 2)); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_known_vectors();
    test_operand_change();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not complete");
  end

endmodule
